// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
// Free-running pixel/line counters with sync windows and an active window.
// {active, hsync, vsync} pass through a DELAY-deep pipeline so they line up with
// colour from a renderer of matching latency, then land in an output register.
// Everything advances only on pix_en cycles.
// Optional build macro VGA_TIMING_FRAME_CTR_EN adds frame_count and vblank_irq.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 100,
    parameter int unsigned H_FP      = 7,
    parameter int unsigned H_SYNC    = 15,
    parameter int unsigned H_BP      = 8,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 37,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 23,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 1,
    parameter int unsigned DELAY     = 1,
    parameter int unsigned HW        = 8,
    parameter int unsigned VW        = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pix_en,
    output logic [HW-1:0]   hcount,
    output logic [VW-1:0]   vcount,
    output logic            active,
    output logic            line_start,
    output logic            frame_start,
    input  logic [3*CW-1:0] rgb_in,
    output logic            hsync,
    output logic            vsync,
`ifdef VGA_TIMING_FRAME_CTR_EN
    output logic [15:0]     frame_count,
    output logic            vblank_irq,
`endif
    output logic [3*CW-1:0] rgb_out
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Reject impossible configurations at elaboration time.
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end
    if (longint'(H_TOTAL) > (longint'(1) << HW)) begin : g_bad_hw
        $error("vga_timing_gen: HW too narrow for H_TOTAL");
    end
    if (longint'(V_TOTAL) > (longint'(1) << VW)) begin : g_bad_vw
        $error("vga_timing_gen: VW too narrow for V_TOTAL");
    end
    if (DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: DELAY must be 0..7");
    end

    logic [HW-1:0]   hcount_q, hcount_d;
    logic [VW-1:0]   vcount_q, vcount_d;
    logic [31:0]     hc32, vc32;
    logic            active_raw, hsync_raw, vsync_raw;
    logic [2:0]      raw_vec;      // {active, hsync, vsync}, syncs as active-high flags
    logic [2:0]      dly_vec;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic [3*CW-1:0] rgb_q, rgb_d;

    assign hc32 = 32'(hcount_q);
    assign vc32 = 32'(vcount_q);

    // Next pixel position: wrap the column at end of line, the line at end of frame.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hc32 == H_TOTAL - 1) begin
                hcount_d = '0;
                if (vc32 == V_TOTAL - 1) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + VW'(1);
                end
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign active_raw = (hc32 < H_ACTIVE) && (vc32 < V_ACTIVE);
    assign hsync_raw  = (hc32 >= HS_START) && (hc32 < HS_END);
    assign vsync_raw  = (vc32 >= VS_START) && (vc32 < VS_END);
    assign raw_vec    = {active_raw, hsync_raw, vsync_raw};

    if (DELAY == 0) begin : g_nodly
        assign dly_vec = raw_vec;
    end else begin : g_dly
        logic [2:0] pipe_q [DELAY];

        // Alignment shift register; cleared to blank with syncs inactive.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(DELAY); i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (pix_en) begin
                pipe_q[0] <= raw_vec;
                for (int i = 1; i < int'(DELAY); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign dly_vec = pipe_q[DELAY-1];
    end

    // Pin values: map sync flags to their polarity, blank colour outside the window.
    always_comb begin
        hsync_d = dly_vec[1] ? HSYNC_POL : ~HSYNC_POL;
        vsync_d = dly_vec[0] ? VSYNC_POL : ~VSYNC_POL;
        rgb_d   = dly_vec[2] ? rgb_in : '0;
    end

    // Output register, held while pix_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= ~HSYNC_POL;
            vsync_q <= ~VSYNC_POL;
            rgb_q   <= '0;
        end else if (pix_en) begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign active      = active_raw;
    assign line_start  = pix_en && (hcount_q == '0);
    assign frame_start = line_start && (vcount_q == '0);
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb_out     = rgb_q;

`ifdef VGA_TIMING_FRAME_CTR_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Frame counter advances on every frame_start and wraps naturally at 16 bits.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_start) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign vblank_irq  = pix_en && (hcount_q == '0) && (vc32 == V_ACTIVE);
`endif

endmodule
